fp16_mul_arb: RTL

Round-robin arbiter and two-stage pipeline wrapper that shares one combinational FP16 multiplier between `N_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block registers the granted pair, drives the shared multiplier, and registers the product with the winning requester's ID on a single valid/ready response port. It sits between the execution lanes and the single FPMUL instance in the ALU.

---
 rtl/fp16_mul_arb.sv | 117 +++++++++++
 1 files changed

// File: rtl/fp16_mul_arb.sv
`default_nettype none
// ============================================================================
// Module   : fp16_mul_arb
// Purpose  : Round-robin arbiter and two-stage pipeline that shares one
//            combinational FP16 multiplier between N_REQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
module fp16_mul_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_REQ-1:0]    req_valid_i,
    input  logic [16*N_REQ-1:0] req_opA_i,
    input  logic [16*N_REQ-1:0] req_opB_i,
    output logic [N_REQ-1:0]    req_ready_o,
    output logic [15:0]         mul_opA_o,
    output logic [15:0]         mul_opB_o,
    input  logic [15:0]         mul_res_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [ID_W-1:0]     rsp_id_o,
    output logic [15:0]         rsp_data_o,
    output logic [15:0]         op_cnt_o
);

    logic             r_s1Vld;
    logic [15:0]      r_s1OpA;
    logic [15:0]      r_s1OpB;
    logic [ID_W-1:0]  r_s1Id;
    logic [ID_W-1:0]  r_ptr;
    logic             r_rspVld;
    logic [ID_W-1:0]  r_rspId;
    logic [15:0]      r_rspData;
    logic [15:0]      r_opCnt;

    logic             w_s2Free;
    logic             w_s1Adv;
    logic             w_s1Free;
    logic             w_grantVld;
    logic [ID_W-1:0]  w_grantIdx;
    logic [ID_W-1:0]  w_cand;
    logic             w_accept;
    logic [N_REQ-1:0] w_reqReady;

    assign w_s2Free = !r_rspVld || rsp_ready_i;
    assign w_s1Adv  = r_s1Vld && w_s2Free;
    assign w_s1Free = !r_s1Vld || w_s1Adv;

    // Scan from farthest to nearest so the requester closest after r_ptr wins.
    always_comb begin
        w_grantVld = 1'b0;
        w_grantIdx = '0;
        w_cand     = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            w_cand = ID_W'((int'(r_ptr) + i) % N_REQ);
            if (req_valid_i[w_cand]) begin
                w_grantVld = 1'b1;
                w_grantIdx = w_cand;
            end
        end
    end

    assign w_accept = w_grantVld && w_s1Free && !rst_i;

    always_comb begin
        w_reqReady = '0;
        if (w_accept) begin
            w_reqReady[w_grantIdx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1Vld   <= 1'b0;
            r_s1OpA   <= '0;
            r_s1OpB   <= '0;
            r_s1Id    <= '0;
            r_ptr     <= ID_W'(N_REQ - 1);
            r_rspVld  <= 1'b0;
            r_rspId   <= '0;
            r_rspData <= '0;
            r_opCnt   <= '0;
        end else begin
            if (w_accept) begin
                r_s1Vld <= 1'b1;
                r_s1OpA <= req_opA_i[16*int'(w_grantIdx) +: 16];
                r_s1OpB <= req_opB_i[16*int'(w_grantIdx) +: 16];
                r_s1Id  <= w_grantIdx;
                r_ptr   <= w_grantIdx;
                r_opCnt <= r_opCnt + 16'd1;
            end else if (w_s1Adv) begin
                r_s1Vld <= 1'b0;
            end

            // S2 payload only moves on advance, so it is held under back-pressure.
            if (w_s1Adv) begin
                r_rspVld  <= 1'b1;
                r_rspId   <= r_s1Id;
                r_rspData <= mul_res_i;
            end else if (rsp_ready_i) begin
                r_rspVld  <= 1'b0;
            end
        end
    end

    assign req_ready_o = w_reqReady;
    assign mul_opA_o   = r_s1OpA;
    assign mul_opB_o   = r_s1OpB;
    assign rsp_valid_o = r_rspVld;
    assign rsp_id_o    = r_rspId;
    assign rsp_data_o  = r_rspData;
    assign op_cnt_o    = r_opCnt;

endmodule
`default_nettype wire
